// File: rtl/mem_access_ctrl_pkg.sv
// Shared opcodes, FSM states and default widths for the nRisc data-memory path.
// Imported by the access controller and by any model of the memory itself.
package nrisc_mem_pkg;

    localparam int DATA_W_DEF         = 8;
    localparam int ADDR_W_DEF         = 8;
    localparam int TIMEOUT_CYCLES_DEF = 16;

    localparam logic [2:0] OP_NOP = 3'b000;
    localparam logic [2:0] OP_SW  = 3'b100;
    localparam logic [2:0] OP_LW  = 3'b101;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    function automatic logic [2:0] op_for(input logic is_write);
        return is_write ? OP_SW : OP_LW;
    endfunction

endpackage

// File: rtl/mem_access_ctrl_if.sv
// Request, memory-bus and response signals between the execute stage, the
// access controller (master) and the requester/memory side (slave).
interface mem_access_ctrl_if
    import nrisc_mem_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF
);
    logic              req_valid;
    logic              req_write;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic              req_ready;
    logic [2:0]        mem_instruction;
    logic [DATA_W-1:0] mem_alpha;
    logic [ADDR_W-1:0] mem_beta;
    logic [DATA_W-1:0] mem_data_in;
    logic              mem_signal;
    logic              rsp_valid;
    logic [DATA_W-1:0] rsp_rdata;
    logic              busy;
    logic              timeout_err;

    modport master (
        input  req_valid, req_write, req_addr, req_wdata, mem_data_in, mem_signal,
        output req_ready, mem_instruction, mem_alpha, mem_beta,
               rsp_valid, rsp_rdata, busy, timeout_err
    );

    modport slave (
        output req_valid, req_write, req_addr, req_wdata, mem_data_in, mem_signal,
        input  req_ready, mem_instruction, mem_alpha, mem_beta,
               rsp_valid, rsp_rdata, busy, timeout_err
    );
endinterface

// File: rtl/mem_access_ctrl_toggle_detect.sv
// Turns the memory's level-toggling done signal into a one-cycle pulse.
// Only changes seen while armed count; otherwise the stored level resyncs.
module toggle_detect (
    input  logic clock,
    input  logic reset,
    input  logic sig,
    input  logic arm,
    output logic done
);
    logic last_sig_r;

    assign done = arm & (sig ^ last_sig_r);

    // Remember the last consumed level of sig
    always_ff @(posedge clock) begin
        if (reset || !arm) begin
            last_sig_r <= sig;
        end else if (done) begin
            last_sig_r <= sig;
        end else begin
            last_sig_r <= last_sig_r;
        end
    end
endmodule

// File: rtl/mem_access_ctrl.sv
// Core-side initiator for the nRisc data memory: one load/store at a time.
// Optional WAIT-state abort is compiled in with NRISC_MEM_TIMEOUT_EN.
module mem_access_ctrl
    import nrisc_mem_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF
`ifdef NRISC_MEM_TIMEOUT_EN
    ,
    parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
`endif
) (
    input  logic              clock,
    input  logic              reset,
    mem_access_ctrl_if.master bus
);
    state_t state_r;
    logic   is_write_r;
    logic   arm_s;
    logic   done_s;

`ifdef NRISC_MEM_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0] wait_cnt_r;
`else
    assign bus.timeout_err = 1'b0;
`endif

    assign arm_s = (state_r == WAIT);

    toggle_detect u_toggle (
        .clock (clock),
        .reset (reset),
        .sig   (bus.mem_signal),
        .arm   (arm_s),
        .done  (done_s)
    );

    // Transfer FSM; all bus and response outputs are registered here
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r             <= IDLE;
            is_write_r          <= 1'b0;
            bus.req_ready       <= 1'b1;
            bus.busy            <= 1'b0;
            bus.mem_instruction <= OP_NOP;
            bus.mem_alpha       <= {DATA_W{1'b0}};
            bus.mem_beta        <= {ADDR_W{1'b0}};
            bus.rsp_valid       <= 1'b0;
            bus.rsp_rdata       <= {DATA_W{1'b0}};
`ifdef NRISC_MEM_TIMEOUT_EN
            wait_cnt_r          <= {CNT_W{1'b0}};
            bus.timeout_err     <= 1'b0;
`endif
        end else begin
            case (state_r)
                IDLE: begin
                    bus.rsp_valid <= 1'b0;
                    if (bus.req_valid) begin
                        state_r             <= ISSUE;
                        is_write_r          <= bus.req_write;
                        bus.req_ready       <= 1'b0;
                        bus.busy            <= 1'b1;
                        bus.mem_instruction <= op_for(bus.req_write);
                        bus.mem_beta        <= bus.req_addr;
                        // Loads present a zero data word so the bus carries no stale store data
                        bus.mem_alpha       <= bus.req_write ? bus.req_wdata : {DATA_W{1'b0}};
                    end else begin
                        state_r <= IDLE;
                    end
                end
                ISSUE: begin
                    state_r             <= WAIT;
                    bus.mem_instruction <= OP_NOP;
`ifdef NRISC_MEM_TIMEOUT_EN
                    wait_cnt_r          <= {CNT_W{1'b0}};
`endif
                end
                WAIT: begin
                    if (done_s) begin
                        state_r       <= RESP;
                        bus.rsp_valid <= 1'b1;
                        if (!is_write_r) begin
                            bus.rsp_rdata <= bus.mem_data_in;
                        end
                    end
`ifdef NRISC_MEM_TIMEOUT_EN
                    else if (wait_cnt_r == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                        state_r         <= RESP;
                        bus.rsp_valid   <= 1'b1;
                        bus.rsp_rdata   <= {DATA_W{1'b0}};
                        bus.timeout_err <= 1'b1;
                    end else begin
                        wait_cnt_r <= wait_cnt_r + CNT_W'(1);
                    end
`else
                    else begin
                        state_r <= WAIT;
                    end
`endif
                end
                RESP: begin
                    state_r       <= IDLE;
                    bus.rsp_valid <= 1'b0;
                    bus.req_ready <= 1'b1;
                    bus.busy      <= 1'b0;
                end
                default: begin
                    state_r             <= IDLE;
                    bus.rsp_valid       <= 1'b0;
                    bus.req_ready       <= 1'b1;
                    bus.busy            <= 1'b0;
                    bus.mem_instruction <= OP_NOP;
                end
            endcase
        end
    end
endmodule

// File: doc/mem_access_ctrl.md
Name: mem_access_ctrl

Overview:
- Core-side initiator for the 8-bit nRisc data memory.
- Accepts one load/store request at a time from the execute stage and drives the memory's 3-bit command, data and address buses.
- Detects completion from the memory's toggling done signal, then returns load data with a one-cycle response pulse.
- Stalls the core (busy) while a transfer is outstanding.

Parameters:
- DATA_W, 8, data bus width.
- ADDR_W, 8, address width; 256-entry memory.
- TIMEOUT_CYCLES, 16, WAIT-state cycles before abort. Used only when the timeout feature is compiled in.

Ports:
- clock  in  1  system clock; all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- req_valid  in  1  request present.
- req_write  in  1  1 = store word, 0 = load word.
- req_addr  in  ADDR_W  target address.
- req_wdata  in  DATA_W  store data.
- req_ready  out  1  high only in IDLE.
- mem_instruction  out  3  000 idle, 100 store word, 101 load word.
- mem_alpha  out  DATA_W  store data to memory.
- mem_beta  out  ADDR_W  address to memory.
- mem_data_in  in  DATA_W  load data from memory.
- mem_signal  in  1  memory done; toggles once per completed command.
- rsp_valid  out  1  one-cycle completion pulse.
- rsp_rdata  out  DATA_W  load result; held until next rsp_valid.
- busy  out  1  high in every state except IDLE.
- timeout_err  out  1  sticky abort flag.

Behaviour:
- Clock and reset: one clock, clock; reset is synchronous and active-high. All state updates on the rising edge of clock.
- Reset values:
  - state = IDLE.
  - mem_instruction = 000; mem_alpha, mem_beta, rsp_rdata = 0.
  - rsp_valid = 0, busy = 0, timeout_err = 0, req_ready = 1.
  - last_sig <= mem_signal, so a stale toggle is never taken as completion.
- States: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - req_ready = 1.
  - On req_valid, latch write/addr/wdata; go to ISSUE.
  - A request is accepted on the cycle req_valid && req_ready.
- ISSUE (exactly 1 cycle):
  - Drive mem_instruction = 100 (store) or 101 (load); mem_beta = addr; mem_alpha = wdata (0 for loads).
  - Go to WAIT.
- WAIT:
  - mem_instruction = 000; mem_beta/mem_alpha hold their values.
  - Completion when mem_signal != last_sig. In that cycle: last_sig <= mem_signal; for loads only, rsp_rdata <= mem_data_in; go to RESP.
- RESP (1 cycle): rsp_valid = 1; go to IDLE.
- Latency:
  - Accept at edge N; command on bus during cycle N+1.
  - Earliest completion detected at edge N+2; rsp_valid high in cycle N+3.
  - Next request can be accepted at edge N+4.
- Stores: rsp_rdata is unchanged.
- Extra toggle while in IDLE: absorbed. last_sig tracks mem_signal in IDLE; no response is generated.
- req_valid while busy: ignored. The requester holds the request until req_ready.
- Reset mid-transfer: immediate return to IDLE with reset values; the outstanding command is abandoned and no rsp_valid is issued.

Optional Feature:
- Macro: NRISC_MEM_TIMEOUT_EN.
- Defined:
  - Counter starts at 0 on entry to WAIT.
  - If it reaches TIMEOUT_CYCLES without a toggle: set timeout_err (sticky until reset), pulse rsp_valid with rsp_rdata = 0, return to IDLE.
  - Counter width is clog2(TIMEOUT_CYCLES+1).
- Undefined: WAIT lasts indefinitely; timeout_err tied to 0; no counter logic.

Decomposition:
- Package nrisc_mem_pkg:
  - Opcode constants OP_NOP = 3'b000, OP_SW = 3'b100, OP_LW = 3'b101.
  - State enum (IDLE/ISSUE/WAIT/RESP).
  - Default widths.
- The memory model and this block both import the package.
- Sub-module toggle_detect: holds last_sig; outputs a one-cycle "done" pulse on level change.
  - Inputs: clock, reset, sig, arm.
  - Resyncs to sig when not armed.

Test Plan:
1. Store: req_write=1, addr=0x3C, wdata=0xA5, accepted at N. Expect mem_instruction=100, mem_beta=0x3C, mem_alpha=0xA5 in N+1 only. Toggle mem_signal at N+2. Expect rsp_valid in N+3 and rsp_rdata unchanged.
2. Load: addr=0x3C, model returns 0xA5 with toggle 3 cycles after issue. Expect mem_instruction=101 for one cycle, busy high throughout, rsp_valid single pulse, rsp_rdata=0xA5.
3. Back-to-back: second req_valid held high during first transfer. Expect req_ready=0 until IDLE, second accepted exactly the cycle after RESP, two distinct rsp_valid pulses.
4. Spurious toggle: mem_signal toggles in IDLE with no request. Expect no rsp_valid and no state change. Then a load with data 0x11 completes normally, rsp_rdata=0x11.
5. Reset mid-WAIT: assert reset for one cycle during WAIT. Expect all outputs at reset values next cycle, no rsp_valid. A late toggle after reset produces no response.
6. With NRISC_MEM_TIMEOUT_EN and TIMEOUT_CYCLES=16: issue a load, never toggle. Expect rsp_valid 16 cycles after entering WAIT, rsp_rdata=0, timeout_err=1 held until reset.
